// File: rtl/imem_responder.sv
// Instruction-memory responder: single-outstanding fetch port with a fixed response latency
// plus a backdoor word-load port. Define IMEM_MISALIGN_ERR_EN to reject misaligned fetches.
module imem_responder #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 2,
  localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [63:0]     req_addr,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [31:0]     resp_inst,
  output logic            resp_err,
  input  logic            ld_en,
  input  logic [IdxW-1:0] ld_idx,
  input  logic [31:0]     ld_data
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  localparam logic [3:0] CntInit = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  logic [31:0] mem [DEPTH];

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] snap_inst_q;
  logic        snap_err_q;
  logic        resp_valid_q;
  logic [31:0] resp_inst_q;
  logic        resp_err_q;

  logic [63:0] offset;
  logic [63:0] word_off;
  logic        in_range;
  logic        misalign;
  logic        rd_err;
  logic [31:0] rd_word;

  // Full-width subtraction; addresses below the base are caught by the explicit compare.
  assign offset   = req_addr - BASE_ADDR;
  assign word_off = offset >> 2;
  assign in_range = (req_addr >= BASE_ADDR) && (word_off < 64'(DEPTH));

`ifdef IMEM_MISALIGN_ERR_EN
  assign misalign = (req_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign rd_err  = !in_range || misalign;
  assign rd_word = rd_err ? 32'h0000_0000 : mem[word_off[IdxW-1:0]];

  assign req_ready  = (state_q == StIdle) && !rst;
  assign resp_valid = resp_valid_q;
  assign resp_inst  = resp_inst_q;
  assign resp_err   = resp_err_q;

  // Storage is never cleared; a load colliding with an acceptance lands after the snapshot.
  always_ff @(posedge clk) begin
    if (!rst && ld_en && (32'(ld_idx) < DEPTH)) begin
      mem[ld_idx] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      snap_inst_q  <= 32'h0;
      snap_err_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_inst_q  <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            if (LATENCY == 0) begin
              state_q      <= StResp;
              resp_valid_q <= 1'b1;
              resp_inst_q  <= rd_word;
              resp_err_q   <= rd_err;
            end else begin
              state_q     <= StWait;
              cnt_q       <= CntInit;
              snap_inst_q <= rd_word;
              snap_err_q  <= rd_err;
            end
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            state_q      <= StResp;
            resp_valid_q <= 1'b1;
            resp_inst_q  <= snap_inst_q;
            resp_err_q   <= snap_err_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          if (resp_ready) begin
            state_q      <= StIdle;
            resp_valid_q <= 1'b0;
            resp_inst_q  <= 32'h0;
            resp_err_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 The block SHALL have the parameter BASE_ADDR, default 64'h0000_0000_8000_0000, giving the byte address of word 0.
REQ-002 The block SHALL have the parameter DEPTH, default 1024, giving the number of 32-bit words stored.
REQ-003 The block SHALL have the parameter LATENCY, default 2, legal range 0..15, giving the wait cycles between request acceptance and the response.
REQ-004 clk  input  1  the single clock; every register SHALL update on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 req_valid  input  1  the fetch initiator presents a request.
REQ-007 req_ready  output  1  the responder can accept a request.
REQ-008 req_addr  input  64  byte address of the instruction.
REQ-009 resp_valid  output  1  a response is present.
REQ-010 resp_ready  input  1  the initiator accepts the response.
REQ-011 resp_inst  output  32  the fetched instruction word.
REQ-012 resp_err  output  1  the request was out of range, or misaligned (see Configuration).
REQ-013 ld_en  input  1  backdoor load strobe.
REQ-014 ld_idx  input  clog2(DEPTH)  word index to write.
REQ-015 ld_data  input  32  word to write.

Function
REQ-016 A request SHALL be accepted on any rising edge where req_valid and req_ready are both 1; at most one request SHALL be outstanding.
REQ-017 The state machine SHALL have three states: IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 On acceptance in IDLE, the state SHALL move to WAIT with a counter loaded to LATENCY-1, or directly to RESP if LATENCY=0.
REQ-019 In WAIT, the counter SHALL decrement once per cycle, and the state SHALL move to RESP on the edge where the counter equals 0.
REQ-020 resp_valid SHALL be 1 exactly in RESP, so the first resp_valid cycle is LATENCY+1 cycles after the acceptance edge.
REQ-021 In RESP, resp_valid, resp_inst and resp_err SHALL hold stable until resp_ready=1; on that edge the state SHALL return to IDLE.
REQ-022 There SHALL be no back-to-back bypass: a new request is accepted no earlier than the cycle after the response handshake.
REQ-023 The word index SHALL be (req_addr - BASE_ADDR) >> 2; the request is in range iff req_addr >= BASE_ADDR and the index < DEPTH, with the subtraction done at the full 64-bit width.
REQ-024 The data SHALL be snapshotted at acceptance; ld_en writes to the same word during WAIT or RESP SHALL NOT change resp_inst.
REQ-025 When ld_en and request acceptance hit the same word on the same edge, the request SHALL return the old data and the load SHALL take effect.
REQ-026 For an out-of-range request, resp_err=1 and resp_inst=32'h0000_0000, with the same latency as a valid request.
REQ-027 Loads via ld_en SHALL be accepted in every state and SHALL be ignored while rst=1.
REQ-028 Outside RESP, resp_inst SHALL be 0 and resp_err SHALL be 0.

Reset
REQ-029 While rst=1: state=IDLE, counter=0, resp_valid=0, resp_inst=0, resp_err=0.
REQ-030 req_ready SHALL be 0 in the reset cycle and 1 from the first cycle after rst falls.
REQ-031 Reset mid-WAIT or mid-RESP SHALL abort the pending response without ever asserting resp_valid for it.
REQ-032 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-033 If IMEM_MISALIGN_ERR_EN is defined, a request with req_addr[1:0]!=0 SHALL return resp_err=1 and resp_inst=0 with normal latency.
REQ-034 If IMEM_MISALIGN_ERR_EN is undefined, req_addr[1:0] SHALL be ignored and the word at the truncated index returned with resp_err=0.

Verification
REQ-035 Basic fetch: LATENCY=2; load idx 0 = 32'h0000_0413; request 0x8000_0000 -> resp_valid rises 3 cycles after acceptance with resp_inst=32'h0000_0413 and resp_err=0.
REQ-036 Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid and resp_inst stay stable and req_ready=0 throughout; one cycle after resp_ready=1, req_ready=1.
REQ-037 Range checks: request 0x7FFF_FFFC and 0x8000_0000+4*DEPTH -> resp_err=1 and resp_inst=0 for both; request 0x8000_0000+4*(DEPTH-1) -> last word returned.
REQ-038 Load collision: accept a request to idx 5 (old value 32'h1111_1111) while ld_en writes 32'h2222_2222 to idx 5 -> response is 32'h1111_1111; the next fetch of idx 5 returns 32'h2222_2222.
REQ-039 Reset during WAIT, and LATENCY=0: assert rst in WAIT -> no resp_valid and IDLE follows; with LATENCY=0 -> resp_valid in the cycle after acceptance.
REQ-040 Misalignment: request 0x8000_0002 with the macro defined -> resp_err=1; without the macro -> word 0 returned with resp_err=0.
